// File: rtl/mac_post_pkg.sv
// Shared widths and arithmetic helpers for the MAC post-processing stage.
// Build option: define MAC_POST_RELU6_EN to clamp at fixed-point 6.0 (ReLU6) instead of full scale.
package mac_post_pkg;

   localparam int DW_DEF    = 32;
   localparam int OW_DEF    = 8;
   localparam int SHIFT_DEF = 8;
   localparam int FRAC_DEF  = 4;
   localparam int DEPTH_DEF = 4;

   localparam int SUMW = DW_DEF + 1;
   localparam int RNDW = DW_DEF + 2;

`ifdef MAC_POST_RELU6_EN
   localparam bit RELU6 = 1'b1;
`else
   localparam bit RELU6 = 1'b0;
`endif

   function automatic int umax_calc(input int ow, input int frac);
      int full_scale;
      int six;
      full_scale = (1 << ow) - 1;
      six        = 6 * (1 << frac);
      return (RELU6 && (six < full_scale)) ? six : full_scale;
   endfunction

   // Round half up, then arithmetic shift; 64 bits leaves headroom for any DW up to 61.
   function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input int sh);
      logic signed [63:0] half;
      half = 64'sd1 <<< (sh - 1);
      return (v + half) >>> sh;
   endfunction

endpackage

// File: rtl/mac_post_proc_if.sv
// Output activation stream from the post-processing FIFO to the write-back path.
interface mac_post_if #(parameter int OW = 8);
   // valid/ready: a transfer occurs on each rising edge where out_valid and out_ready are both 1;
   // out_data holds steady while out_valid=1 and out_ready=0, and out_valid never drops without a transfer.
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/post_fifo.sv
// Small synchronous FIFO; the head entry is read straight from the storage registers.
module post_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // When full, a simultaneous pop frees the slot at wr_ptr (== rd_ptr) for the incoming write.
   assign dout  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/mac_post_proc.sv
// MAC post-processing: bias add, rounding requantise, ReLU clamp and output FIFO.
// Build option: MAC_POST_RELU6_EN selects the ReLU6 clamp ceiling (see mac_post_pkg).
module mac_post_proc
   import mac_post_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int OW    = OW_DEF,
   parameter int SHIFT = SHIFT_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] mac_result,
   input  logic          mac_done,
   input  logic [DW-1:0] bias,
   input  logic          bias_ld,
   input  logic          ovf_clr,
   output logic          ovf,
   mac_post_if.master    out_if
);

   localparam int            UMAX   = umax_calc(OW, FRAC);
   localparam logic [OW-1:0] UMAX_V = OW'(UMAX);

   logic [DW-1:0]        bias_reg;
   logic signed [DW:0]   s1_sum;
   logic                 s1_vld;
   logic [OW-1:0]        s2_data;
   logic                 s2_vld;
   logic signed [63:0]   rnd;
   logic [OW-1:0]        clamp_q;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 pop;
   logic                 push;
   logic                 drop;

   always_comb begin
      rnd = round_shift({{(63-DW){s1_sum[DW]}}, s1_sum}, SHIFT);
      if (rnd < 0)
         clamp_q = '0;
      else if (rnd > longint'(UMAX))
         clamp_q = UMAX_V;
      else
         clamp_q = rnd[OW-1:0];
   end

   // Capture reads bias_reg before this edge's load, so a coincident bias_ld applies to the next result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bias_reg <= '0;
         s1_sum   <= '0;
         s1_vld   <= 1'b0;
         s2_data  <= '0;
         s2_vld   <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (bias_ld) bias_reg <= bias;
         s1_vld <= mac_done;
         if (mac_done)
            s1_sum <= $signed({mac_result[DW-1], mac_result}) + $signed({bias_reg[DW-1], bias_reg});
         s2_vld <= s1_vld;
         if (s1_vld) s2_data <= clamp_q;
         if (drop)
            ovf <= 1'b1;
         else if (ovf_clr)
            ovf <= 1'b0;
      end
   end

   assign pop  = out_if.out_valid & out_if.out_ready;
   assign push = s2_vld & (~fifo_full | pop);
   assign drop = s2_vld & fifo_full & ~pop;

   post_fifo #(.W(OW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .din   (s2_data),
      .dout  (out_if.out_data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign out_if.out_valid = ~fifo_empty;

endmodule

// File: tb/tb_mac_post_proc.sv
// Self-checking bench for mac_post_proc: directed corner cases plus randomized traffic vs a queue model.
module tb_mac_post_proc;

   localparam int DW    = 32;
   localparam int OW    = 8;
   localparam int SHIFT = 8;
   localparam int FRAC  = 4;
   localparam int DEPTH = 4;
`ifdef MAC_POST_RELU6_EN
   localparam int EXP_MAX = 96;
`else
   localparam int EXP_MAX = 255;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] mac_result = '0;
   logic [DW-1:0] bias = '0;
   logic          mac_done = 1'b0;
   logic          bias_ld = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          ovf;

   int total = 0;
   int bad   = 0;

   mac_post_if #(.OW(OW)) out_if ();

   mac_post_proc #(.DW(DW), .OW(OW), .SHIFT(SHIFT), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mac_result (mac_result),
      .mac_done   (mac_done),
      .bias       (bias),
      .bias_ld    (bias_ld),
      .ovf_clr    (ovf_clr),
      .ovf        (ovf),
      .out_if     (out_if)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   // ---------------- reference model / scoreboard ----------------
   function automatic int ref_act(input longint m, input longint b);
      longint v;
      longint q;
      longint den;
      den = longint'(1) << SHIFT;
      v   = m + b + (den / 2);
      q   = v / den;
      if ((v % den) != 0 && v < 0) q = q - 1;
      if (q < 0) return 0;
      if (q > EXP_MAX) return EXP_MAX;
      return int'(q);
   endfunction

   logic [OW-1:0] exp_q[$];
   int            pend_val[$];
   int            pend_due[$];
   longint        bias_m;
   bit            ovf_m;
   int            cyc = 0;

   always begin
      bit pop_m;
      bit drop_m;
      int n_before;
      int v;
      @(posedge clk);
      cyc++;
      drop_m = 1'b0;
      if (!rst_n) begin
         exp_q.delete();
         pend_val.delete();
         pend_due.delete();
         bias_m = 0;
         ovf_m  = 1'b0;
      end else begin
         n_before = exp_q.size();
         pop_m = (n_before > 0) && out_if.out_ready;
         if (pop_m) void'(exp_q.pop_front());
         if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            v = pend_val.pop_front();
            void'(pend_due.pop_front());
            if (n_before < DEPTH || pop_m) exp_q.push_back(OW'(v));
            else drop_m = 1'b1;
         end
         if (ovf_clr) ovf_m = 1'b0;
         if (drop_m) ovf_m = 1'b1;
         if (mac_done) begin
            pend_val.push_back(ref_act(longint'($signed(mac_result)), bias_m));
            pend_due.push_back(cyc + 2);
         end
         if (bias_ld) bias_m = longint'($signed(bias));
      end
      #1;
      check_val("sb_valid", out_if.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check_val("sb_data", out_if.out_data, exp_q[0]);
      check_val("sb_ovf", ovf, ovf_m);
   end

   // ---------------- driver tasks ----------------
   task automatic mac_drive(input logic [DW-1:0] m, input bit bl, input logic [DW-1:0] b);
      @(negedge clk);
      mac_result = m;
      mac_done   = 1'b1;
      bias_ld    = bl;
      bias       = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mac_done   = 1'b0;
         bias_ld    = 1'b0;
         ovf_clr    = 1'b0;
         mac_result = $urandom;
         bias       = $urandom;
      end
   endtask

   task automatic bias_load(input logic [DW-1:0] b);
      @(negedge clk);
      mac_done = 1'b0;
      bias_ld  = 1'b1;
      bias     = b;
      idle(1);
   endtask

   // One result into an empty FIFO: not visible after edge N+1, visible with value exp_v after N+2.
   task automatic one_result(input string tag, input logic [DW-1:0] m, input bit bl,
                             input logic [DW-1:0] b, input int exp_v);
      idle(3);
      mac_drive(m, bl, b);
      idle(1);
      @(posedge clk); #1;
      check_val({tag, "_lat1"}, out_if.out_valid, 0);
      @(posedge clk); #1;
      check_val({tag, "_valid"}, out_if.out_valid, 1);
      check_val({tag, "_data"}, out_if.out_data, exp_v);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      out_if.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check_val("rst_valid", out_if.out_valid, 0);
      check_val("rst_data", out_if.out_data, 0);
      check_val("rst_ovf", ovf, 0);
      @(negedge clk);
      rst_n = 1'b1;

      one_result("basic", 32'h0000_1280, 1'b0, '0, 19);
      one_result("neg", 32'hFFFF_F000, 1'b0, '0, 0);
      one_result("sat", 32'h0001_0000, 1'b0, '0, EXP_MAX);
      one_result("bias_old", 32'h0, 1'b1, 32'd256, 0);
      one_result("bias_new", 32'h0, 1'b0, '0, 1);
      bias_load('0);

      // backpressure: four fit, the fifth is dropped
      idle(3);
      out_if.out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) mac_drive(DW'(k * 256), 1'b0, '0);
      idle(5);
      check_val("bp_ovf", ovf, 1);
      check_val("bp_valid", out_if.out_valid, 1);
      check_val("bp_hold", out_if.out_data, 1);
      idle(1);
      check_val("bp_hold2", out_if.out_data, 1);
      out_if.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check_val("bp_pop", out_if.out_data, k);
         check_val("bp_pop_valid", out_if.out_valid, 1);
         @(negedge clk);
      end
      check_val("bp_empty", out_if.out_valid, 0);
      ovf_clr = 1'b1;
      idle(1);
      check_val("ovf_clr", ovf, 0);

      // asynchronous reset with three entries queued
      out_if.out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) mac_drive(DW'(k * 512), 1'b0, '0);
      idle(4);
      check_val("pre_rst_valid", out_if.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_valid", out_if.out_valid, 0);
      check_val("arst_ovf", ovf, 0);
      check_val("arst_data", out_if.out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      out_if.out_ready = 1'b1;
      @(posedge clk); #1;
      check_val("post_rst_empty", out_if.out_valid, 0);

      // randomized traffic, checked every cycle by the scoreboard
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         mac_done = ($urandom_range(0, 99) < 55);
         if ($urandom_range(0, 19) == 0) mac_result = $urandom;
         else mac_result = DW'($signed($urandom_range(0, 140000)) - 70000);
         bias_ld = ($urandom_range(0, 9) == 0);
         bias    = DW'($signed($urandom_range(0, 4000)) - 2000);
         ovf_clr = ($urandom_range(0, 19) == 0);
         out_if.out_ready = ($urandom_range(0, 99) < 60);
      end
      idle(1);
      out_if.out_ready = 1'b1;
      idle(8);
      check_val("drain_empty", out_if.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
